bcd_modulo_counter: RTL

BCD_MODULO_COUNTER -- requirements
Module: bcd_modulo_counter

---
 rtl/bcd_modulo_counter_if.sv | 35 +++
 rtl/bcd_modulo_counter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/bcd_modulo_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_modulo_counter_if
// Bundles the control, data and status signals of one BCD modulo counter.
//   ena      count enable
//   up       direction, 1 = increment, 0 = decrement
//   clr      synchronous clear to zero
//   load     synchronous load of d
//   d        packed BCD load value, digit 0 in [3:0]
//   q        current count, packed BCD, digit 0 in [3:0]
//   out      combinational terminal count, used to cascade the next stage
//   load_err one-cycle flag following a rejected load
// The master modport drives the controls; the counter sits on the slave side.
// ---------------------------------------------------------------------------
interface bcd_modulo_counter_if #(
    parameter int DIGITS = 2
);
    logic                  ena;
    logic                  up;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   d;
    logic [4*DIGITS-1:0]   q;
    logic                  out;
    logic                  load_err;

    modport master (
        output ena, up, clr, load, d,
        input  q, out, load_err
    );

    modport slave (
        input  ena, up, clr, load, d,
        output q, out, load_err
    );
endinterface

// File: rtl/bcd_modulo_counter.sv
// ---------------------------------------------------------------------------
// bcd_modulo_counter
// Up/down BCD counter cycling through 0..MODULUS-1 with synchronous clear,
// validated synchronous load and a combinational terminal-count output that
// lets a following stage advance on the same edge this stage wraps.
//   clk    system clock, rising edge active
//   reset  asynchronous active-high reset, clears q and load_err
//   bus    slave side of bcd_modulo_counter_if (ena, up, clr, load, d in;
//          q, out, load_err out)
// Parameters: DIGITS (1..4) BCD digits, MODULUS (2..10^DIGITS) count length.
// ---------------------------------------------------------------------------
module bcd_modulo_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_modulo_counter_if.slave   bus
);

    localparam int W = 4 * DIGITS;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Elaboration-time constant only: the wrap value written as BCD digits.
    function automatic logic [15:0] constToBcd(input int v);
        logic [15:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

    if (DIGITS < 1 || DIGITS > 4) begin : gBadDigits
        $error("bcd_modulo_counter: DIGITS=%0d outside 1..4", DIGITS);
    end else if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : gBadModulus
        $error("bcd_modulo_counter: MODULUS=%0d outside 2..10^DIGITS", MODULUS);
    end

    localparam logic [15:0]  MAX_FULL = constToBcd(MODULUS - 1);
    localparam logic [W-1:0] MAX_BCD  = MAX_FULL[W-1:0];

    logic [W-1:0] qReg;
    logic [W-1:0] qNext;
    logic         errReg;
    logic         errNext;
    logic [W-1:0] incVal;
    logic [W-1:0] decVal;
    logic         carry;
    logic         borrow;
    logic [3:0]   digit;
    logic         dDigitsOk;
    logic         dValid;
    logic         terminal;

    // Ripple carry and borrow chains, one 4-bit digit at a time: a digit
    // rolls 9->0 (or 0->9) and passes the carry/borrow to the next digit.
    always_comb begin
        incVal = '0;
        decVal = '0;
        carry  = 1'b1;
        borrow = 1'b1;
        digit  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = qReg[4*i +: 4];
            if (carry && digit == 4'd9) begin
                incVal[4*i +: 4] = 4'd0;
            end else if (carry) begin
                incVal[4*i +: 4] = digit + 4'd1;
                carry            = 1'b0;
            end else begin
                incVal[4*i +: 4] = digit;
            end
            if (borrow && digit == 4'd0) begin
                decVal[4*i +: 4] = 4'd9;
            end else if (borrow) begin
                decVal[4*i +: 4] = digit - 4'd1;
                borrow           = 1'b0;
            end else begin
                decVal[4*i +: 4] = digit;
            end
        end
    end

    // With every digit at most 9, packed BCD compares in numeric order, so
    // the range check against MAX_BCD is a plain vector compare.
    always_comb begin
        dDigitsOk = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.d[4*i +: 4] > 4'd9) begin
                dDigitsOk = 1'b0;
            end
        end
    end

    assign dValid   = dDigitsOk && (bus.d <= MAX_BCD);
    assign terminal = bus.up ? (qReg == MAX_BCD) : (qReg == '0);

    // Kept unregistered so a cascaded stage steps on the same edge.
    assign bus.out  = bus.ena & ~bus.clr & ~bus.load & terminal;

    // Next count in priority order clr, load, ena; otherwise hold.
    always_comb begin
        qNext   = qReg;
        errNext = 1'b0;
        if (bus.clr) begin
            qNext = '0;
        end else if (bus.load) begin
            qNext   = dValid ? bus.d : '0;
            errNext = ~dValid;
        end else if (bus.ena) begin
            if (bus.up) begin
                qNext = terminal ? '0 : incVal;
            end else begin
                qNext = terminal ? MAX_BCD : decVal;
            end
        end
    end

    // Count and error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qReg   <= '0;
            errReg <= 1'b0;
        end else begin
            qReg   <= qNext;
            errReg <= errNext;
        end
    end

    assign bus.q        = qReg;
    assign bus.load_err = errReg;

endmodule
